// File: rtl/vrf_pkg.sv
// Shared sizes, index type, vector type and round-robin pointer encoding
// for the vector register-file writeback path.
package vrf_pkg;

    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned WIDTH     = 16;

    typedef logic [REG_IDX_W-1:0]         reg_idx_t;
    typedef logic [WIDTH-1:0][WIDTH-1:0]  vec_t;

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } rr_ptr_e;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]/grant[0] = ALU, req[1]/grant[1] = LSU.
// The pointer names the requester that wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    import vrf_pkg::*;

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (rst) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (ptr_q == PTR_ALU) ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
            // After any grant the other requester gets priority.
            if (grant[REQ_ALU]) begin
                ptr_d = PTR_LSU;
            end else if (grant[REQ_LSU]) begin
                ptr_d = PTR_ALU;
            end
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Vector register-file writeback arbiter: issue scoreboard (RAW/WAW stall),
// ALU/LSU round-robin writeback arbitration and a one-cycle write-port register.
module vrf_wb_arbiter #(
    parameter int unsigned WIDTH = vrf_pkg::WIDTH,
    parameter int unsigned NREG  = vrf_pkg::NREG
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                issue_valid,
    input  logic [vrf_pkg::REG_IDX_W-1:0]       issue_rs1,
    input  logic [vrf_pkg::REG_IDX_W-1:0]       issue_rs2,
    input  logic [vrf_pkg::REG_IDX_W-1:0]       issue_rs3,
    input  logic [vrf_pkg::REG_IDX_W-1:0]       issue_rd,
    output logic                                issue_ready,
    input  logic                                alu_valid,
    input  logic [vrf_pkg::REG_IDX_W-1:0]       alu_rd,
    input  logic [WIDTH*WIDTH-1:0]              alu_wd,
    output logic                                alu_ready,
    input  logic                                lsu_valid,
    input  logic [vrf_pkg::REG_IDX_W-1:0]       lsu_rd,
    input  logic [WIDTH*WIDTH-1:0]              lsu_wd,
    output logic                                lsu_ready,
    output logic                                WEV,
    output logic [vrf_pkg::REG_IDX_W-1:0]       RD,
    output logic [WIDTH*WIDTH-1:0]              WD,
    output logic [NREG-1:0]                     busy,
    output logic                                err_wb
);
    import vrf_pkg::*;

    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 gnt_valid;
    reg_idx_t             gnt_rd;
    logic [WIDTH*WIDTH-1:0] gnt_wd;

    logic [NREG-1:0]      busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 wev_q, wev_d;
    reg_idx_t             rd_q, rd_d;
    logic [WIDTH*WIDTH-1:0] wd_q, wd_d;

    assign req = {lsu_valid, alu_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign alu_ready = grant[REQ_ALU];
    assign lsu_ready = grant[REQ_LSU];
    assign gnt_valid = |grant;
    assign gnt_rd    = grant[REQ_LSU] ? lsu_rd : alu_rd;
    assign gnt_wd    = grant[REQ_LSU] ? lsu_wd : alu_wd;

    assign issue_ready = rst && issue_valid
                         && !busy_q[issue_rs1] && !busy_q[issue_rs2]
                         && !busy_q[issue_rs3] && !busy_q[issue_rd];

    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        wev_d  = gnt_valid;
        rd_d   = rd_q;
        wd_d   = wd_q;
        if (gnt_valid) begin
            rd_d = gnt_rd;
            wd_d = gnt_wd;
            if (!busy_q[gnt_rd]) begin
                err_d = 1'b1;
            end
        end
        // Clear before set: the issue stall guarantees they never hit the same bit.
        if (wev_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_ready) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
            wev_q  <= 1'b0;
            rd_q   <= '0;
            wd_q   <= '0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            wev_q  <= wev_d;
            rd_q   <= rd_d;
            wd_q   <= wd_d;
        end
    end

    assign WEV    = wev_q;
    assign RD     = rd_q;
    assign WD     = wd_q;
    assign busy   = busy_q;
    assign err_wb = err_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed self-checking bench for vrf_wb_arbiter with hand-computed expectations.
module tb_vrf_wb_arbiter;

    localparam int unsigned W = 16;

    logic           clk;
    logic           rst;
    logic           issue_valid;
    logic [4:0]     issue_rs1, issue_rs2, issue_rs3, issue_rd;
    logic           issue_ready;
    logic           alu_valid;
    logic [4:0]     alu_rd;
    logic [W*W-1:0] alu_wd;
    logic           alu_ready;
    logic           lsu_valid;
    logic [4:0]     lsu_rd;
    logic [W*W-1:0] lsu_wd;
    logic           lsu_ready;
    logic           WEV;
    logic [4:0]     RD;
    logic [W*W-1:0] WD;
    logic [31:0]    busy;
    logic           err_wb;

    int unsigned n_chk;
    int unsigned n_fail;

    localparam logic [W*W-1:0] WD_A = {16{16'h1234}};
    localparam logic [W*W-1:0] WD_B = {16{16'hBEEF}};
    localparam logic [W*W-1:0] WD_C = {16{16'h0F5A}};

    vrf_wb_arbiter #(.WIDTH(16), .NREG(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rs3   (issue_rs3),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_wd      (alu_wd),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_wd      (lsu_wd),
        .lsu_ready   (lsu_ready),
        .WEV         (WEV),
        .RD          (RD),
        .WD          (WD),
        .busy        (busy),
        .err_wb      (err_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        issue_valid = 1'b0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;

        // Reset state; readies held low while in reset.
        repeat (2) @(negedge clk);
        issue_valid = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wev", WEV, 0);
        chk("rst_rd", RD, 0);
        chk("rst_wd", WD, 0);
        chk("rst_err", err_wb, 0);
        issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;

        // Issue rd=3, then a dependent rs1=3 stalls.
        @(negedge clk);
        rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
        #1 chk("a_issue_ready", issue_ready, 1);
        @(negedge clk);
        chk("a_busy", busy, 32'h0000_0008);
        issue_rs1 = 5'd3; issue_rd = 5'd4;
        #1 chk("a_raw_stall", issue_ready, 0);

        // ALU writes r3; stalled issue accepted two cycles after the grant.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = WD_A;
        #1;
        chk("b_alu_ready", alu_ready, 1);
        chk("b_lsu_ready", lsu_ready, 0);
        chk("b_issue_stall0", issue_ready, 0);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("b_wev", WEV, 1);
        chk("b_rd", RD, 3);
        chk("b_wd", WD, WD_A);
        chk("b_busy_held", busy, 32'h0000_0008);
        chk("b_issue_stall1", issue_ready, 0);
        @(negedge clk);
        #1;
        chk("b_wev_off", WEV, 0);
        chk("b_rd_hold", RD, 3);
        chk("b_busy_clr", busy, 0);
        chk("b_issue_go", issue_ready, 1);
        chk("b_err", err_wb, 0);
        @(negedge clk);
        issue_valid = 1'b0; issue_rs1 = '0;
        #1 chk("b_busy_r4", busy, 32'h0000_0010);

        // LSU writes non-busy r7: write happens, err_wb sticks.
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = WD_B;
        #1;
        chk("c_lsu_ready", lsu_ready, 1);
        chk("c_alu_ready", alu_ready, 0);
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        chk("c_wev", WEV, 1);
        chk("c_rd", RD, 7);
        chk("c_wd", WD, WD_B);
        chk("c_err", err_wb, 1);
        @(negedge clk);
        #1;
        chk("c_wev_off", WEV, 0);
        chk("c_err_sticky", err_wb, 1);
        chk("c_busy", busy, 32'h0000_0010);

        // WAW: back-to-back issue to r5 waits for r5 writeback.
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 chk("d_issue1", issue_ready, 1);
        @(negedge clk);
        #1;
        chk("d_busy", busy, 32'h0000_0030);
        chk("d_waw_stall0", issue_ready, 0);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = WD_C;
        #1;
        chk("d_waw_stall1", issue_ready, 0);
        chk("d_alu_ready", alu_ready, 1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("d_wev", WEV, 1);
        chk("d_rd", RD, 5);
        chk("d_waw_stall2", issue_ready, 0);
        @(negedge clk);
        #1;
        chk("d_busy_clr", busy, 32'h0000_0010);
        chk("d_issue2", issue_ready, 1);
        @(negedge clk);
        issue_valid = 1'b0;
        #1 chk("d_busy_reset", busy, 32'h0000_0030);

        // Reset, then both requesters for 4 cycles: ALU, LSU, ALU, LSU.
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("e_busy", busy, 0);
        chk("e_err", err_wb, 0);
        chk("e_wev", WEV, 0);
        rst = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd1; lsu_rd = 5'd2; alu_wd = WD_A; lsu_wd = WD_B;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("e_alu_ready%0d", k), alu_ready, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("e_lsu_ready%0d", k), lsu_ready, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("e_wev%0d", k), WEV, (k > 0) ? 1 : 0);
            if (k > 0) begin
                chk($sformatf("e_rd%0d", k), RD, ((k - 1) % 2 == 0) ? 1 : 2);
            end
            @(negedge clk);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        chk("e_wev_last", WEV, 1);
        chk("e_rd_last", RD, 2);
        chk("e_wd_last", WD, WD_B);

        // Reset during the WEV cycle with the pointer on LSU.
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = WD_C;
        #1 chk("f_alu_ready", alu_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd10;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        chk("f_wev_pre", WEV, 1);
        chk("f_busy_pre", busy, 32'h0000_0200);
        chk("f_rst_alu_ready", alu_ready, 0);
        chk("f_rst_lsu_ready", lsu_ready, 0);
        chk("f_rst_issue_ready", issue_ready, 0);
        @(negedge clk);
        rst = 1'b1; issue_valid = 1'b0;
        #1;
        chk("f_wev", WEV, 0);
        chk("f_busy", busy, 0);
        chk("f_err", err_wb, 0);
        chk("f_ptr_alu", alu_ready, 1);
        chk("f_ptr_lsu", lsu_ready, 0);
        alu_valid = 1'b0;
        #1 chk("f_single_lsu", lsu_ready, 1);
        lsu_valid = 1'b0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
